// File: rtl/any1_pkg.sv
// Shared types and constants for the any1 instruction-align front end.
package any1_pkg;

  typedef logic [31:0] Address;
  typedef logic [31:0] Instruction;

  localparam Address      RSTIP        = 32'hFFFD_0000;
  localparam int unsigned IALIGN_WORDS = 16;

  typedef enum logic [1:0] {
    EMPTY,
    EMIT,
    DRAIN
  } sIAlignState;

  typedef struct packed {
    logic [5:0]   Stream;
    Address       ip;
    Address       pip;
    logic         predict_taken;
    logic [511:0] cacheline;
  } sInstAlignIn;

  typedef struct packed {
    logic [5:0]  Stream;
    Address      ip;
    Address      pip;
    logic        predict_taken;
    Instruction  ir;
  } sInstAlignOut;

  typedef struct packed {
    Address redirect_ip;
  } sRedirect;

  function automatic Address next_line_adr(input logic [25:0] base);
    return {base + 26'd1, 6'd0};
  endfunction

endpackage

// File: rtl/any1_insn_extract.sv
// Combinational selection of one 32-bit word from a 512-bit cache line.
module any1_insn_extract
  import any1_pkg::*;
(
  input  logic [511:0] cacheline,
  input  logic [3:0]   word,
  output Instruction   ir
);

  always_comb begin
    ir = cacheline[{word, 5'd0} +: 32];
  end

endmodule

// File: rtl/any1_ialign_queue.sv
// Instruction-align queue: buffers I-cache lines and issues one aligned word per handshake.
// Define ANY1_IALIGN_PREFETCH_EN for a second line buffer and zero-bubble line crossing.
module any1_ialign_queue
  import any1_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         line_v_i,
  output logic         line_rdy_o,
  input  sInstAlignIn  line_i,
  output logic         ins_v_o,
  input  logic         ins_rdy_i,
  output sInstAlignOut ins_o,
  input  logic         flush_i,
  input  sRedirect     rdx_i,
  output logic         fetch_req_o,
  output Address       fetch_adr_o,
  output logic [5:0]   stream_o
);

`ifdef ANY1_IALIGN_PREFETCH_EN
  localparam bit         PREFETCH = 1'b1;
  localparam logic [1:0] LINE_CAP = 2'd2;
`else
  localparam bit         PREFETCH = 1'b0;
  localparam logic [1:0] LINE_CAP = 2'd1;
`endif

  localparam logic [3:0] LAST_WORD = 4'(IALIGN_WORDS - 1);

  sIAlignState  state_q, state_d;
  logic         started_q;
  logic [511:0] a_line_q;
  logic         b_v_q;
  logic [511:0] b_line_q;
  logic [25:0]  b_base_q;
  logic [3:0]   b_idx_q;
  logic         b_pt_q;
  logic         start_pend_q;
  logic [3:0]   start_idx_q;

  logic         busy, hs, last_hs, take_in;
  logic [3:0]   in_idx;
  logic         load, activate, pop_b, to_slot_b;
  logic         nxt_v, nxt_b_v;
  logic [3:0]   nxt_idx;
  logic [511:0] sel_line;
  logic [25:0]  sel_base;
  logic [3:0]   sel_idx;
  logic         sel_pt;
  Instruction   sel_ir;
  Address       sel_ip;
  logic         unused_bits;

  assign unused_bits = ^{line_i.pip, line_i.ip[1:0], rdx_i.redirect_ip[1:0]};

  any1_insn_extract u_extract (
    .cacheline (sel_line),
    .word      (sel_idx),
    .ir        (sel_ir)
  );

  // The output register holds the presented word; a_line_q backs the rest of its line,
  // slot b holds a queued line which is promoted straight into the output on word 15.
  always_comb begin
    busy      = (state_q != EMPTY);
    hs        = busy && ins_rdy_i;
    last_hs   = hs && (ins_o.ip[5:2] == LAST_WORD);
    take_in   = line_v_i && line_rdy_o && (line_i.Stream == stream_o) && !flush_i;
    in_idx    = start_pend_q ? start_idx_q : line_i.ip[5:2];

    sel_line  = a_line_q;
    sel_base  = ins_o.ip[31:6];
    sel_idx   = ins_o.ip[5:2] + 4'd1;
    sel_pt    = 1'b0;
    load      = 1'b0;
    activate  = 1'b0;
    pop_b     = 1'b0;
    to_slot_b = 1'b0;
    nxt_v     = busy;

    if (hs && !last_hs) begin
      load = 1'b1;
    end else if (!busy || last_hs) begin
      if (b_v_q) begin
        sel_line  = b_line_q;
        sel_base  = b_base_q;
        sel_idx   = b_idx_q;
        sel_pt    = b_pt_q;
        load      = 1'b1;
        activate  = 1'b1;
        pop_b     = 1'b1;
        to_slot_b = take_in;
      end else if (take_in) begin
        sel_line  = line_i.cacheline;
        sel_base  = line_i.ip[31:6];
        sel_idx   = in_idx;
        sel_pt    = line_i.predict_taken;
        load      = 1'b1;
        activate  = 1'b1;
      end
      nxt_v = load;
    end else begin
      to_slot_b = take_in;
    end

    sel_ip  = {sel_base, sel_idx, 2'b00};
    nxt_b_v = (b_v_q && !pop_b) || to_slot_b;
    nxt_idx = load ? sel_idx : ins_o.ip[5:2];

    if (!nxt_v)
      state_d = EMPTY;
    else if ((nxt_idx == LAST_WORD) && !nxt_b_v)
      state_d = DRAIN;
    else
      state_d = EMIT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EMPTY;
      started_q    <= 1'b0;
      a_line_q     <= '0;
      b_v_q        <= 1'b0;
      b_line_q     <= '0;
      b_base_q     <= '0;
      b_idx_q      <= '0;
      b_pt_q       <= 1'b0;
      start_pend_q <= 1'b0;
      start_idx_q  <= '0;
      ins_v_o      <= 1'b0;
      ins_o        <= '0;
      line_rdy_o   <= 1'b0;
      fetch_req_o  <= 1'b0;
      fetch_adr_o  <= RSTIP;
      stream_o     <= '0;
    end else begin
      fetch_req_o <= 1'b0;
      if (!started_q) begin
        started_q   <= 1'b1;
        fetch_req_o <= 1'b1;
        fetch_adr_o <= RSTIP;
        line_rdy_o  <= 1'b1;
      end else if (flush_i) begin
        state_q      <= EMPTY;
        ins_v_o      <= 1'b0;
        ins_o        <= '0;
        b_v_q        <= 1'b0;
        stream_o     <= stream_o + 6'd1;
        start_pend_q <= 1'b1;
        start_idx_q  <= rdx_i.redirect_ip[5:2];
        fetch_req_o  <= 1'b1;
        fetch_adr_o  <= {rdx_i.redirect_ip[31:6], 6'd0};
        line_rdy_o   <= 1'b1;
      end else begin
        state_q <= state_d;
        ins_v_o <= nxt_v;
        b_v_q   <= nxt_b_v;
        if (load) begin
          ins_o.Stream        <= stream_o;
          ins_o.ip            <= sel_ip;
          ins_o.pip           <= sel_ip + 32'd4;
          ins_o.predict_taken <= sel_pt;
          ins_o.ir            <= sel_ir;
        end
        if (activate)
          a_line_q <= sel_line;
        if (to_slot_b) begin
          b_line_q <= line_i.cacheline;
          b_base_q <= line_i.ip[31:6];
          b_idx_q  <= in_idx;
          b_pt_q   <= line_i.predict_taken;
        end
        if (take_in)
          start_pend_q <= 1'b0;
        line_rdy_o <= (({1'b0, nxt_v} + {1'b0, nxt_b_v}) < LINE_CAP);
        if (PREFETCH && activate) begin
          fetch_req_o <= 1'b1;
          fetch_adr_o <= next_line_adr(sel_base);
        end else if (!PREFETCH && last_hs) begin
          fetch_req_o <= 1'b1;
          fetch_adr_o <= next_line_adr(ins_o.ip[31:6]);
        end
      end
    end
  end

endmodule

// File: tb/tb_any1_ialign_queue.sv
// Self-checking bench for any1_ialign_queue against a word-queue reference model.
module tb_any1_ialign_queue;
  import any1_pkg::*;

`ifdef ANY1_IALIGN_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         line_v_i = 1'b0;
  logic         line_rdy_o;
  sInstAlignIn  line_i;
  logic         ins_v_o;
  logic         ins_rdy_i = 1'b0;
  sInstAlignOut ins_o;
  logic         flush_i = 1'b0;
  sRedirect     rdx_i;
  logic         fetch_req_o;
  Address       fetch_adr_o;
  logic [5:0]   stream_o;

  always #5 clk_i = ~clk_i;

  any1_ialign_queue dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .line_v_i    (line_v_i),
    .line_rdy_o  (line_rdy_o),
    .line_i      (line_i),
    .ins_v_o     (ins_v_o),
    .ins_rdy_i   (ins_rdy_i),
    .ins_o       (ins_o),
    .flush_i     (flush_i),
    .rdx_i       (rdx_i),
    .fetch_req_o (fetch_req_o),
    .fetch_adr_o (fetch_adr_o),
    .stream_o    (stream_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: every accepted matching line expands into its expected word list.
  typedef struct {
    Address     ip;
    logic       pt;
    Instruction ir;
    logic       last;
  } exp_word_t;

  exp_word_t   m_words[$];
  Address      m_line_next[$];
  Address      m_fetch[$];
  int unsigned m_stream = 0;
  logic        m_pend = 1'b0;
  int unsigned m_pend_idx = 0;
  bit          mon_en = 1'b0;
  int unsigned n_hs = 0;
  Address      hold_ip = '1;
  int unsigned hold_seen = 0;
  int unsigned rdy_mode = 0;
  int unsigned hold_cnt = 0;

  function automatic void model_accept(input sInstAlignIn l);
    int unsigned first;
    Address      base;
    if (int'(l.Stream) != int'(m_stream)) return;
    first  = m_pend ? m_pend_idx : int'(l.ip[5:2]);
    m_pend = 1'b0;
    base   = {l.ip[31:6], 6'd0};
    for (int unsigned w = first; w < 16; w++) begin
      exp_word_t e;
      e.ip   = base + w * 4;
      e.pt   = (w == first) ? l.predict_taken : 1'b0;
      e.ir   = l.cacheline[w*32 +: 32];
      e.last = (w == 15);
      m_words.push_back(e);
    end
    if (PF && m_line_next.size() == 0) m_fetch.push_back(base + 64);
    m_line_next.push_back(base + 64);
  endfunction

  function automatic void model_reset();
    m_words.delete();
    m_line_next.delete();
    m_fetch.delete();
    m_stream = 0;
    m_pend   = 1'b0;
  endfunction

  initial begin : monitor
    sInstAlignOut held;
    bit           held_v;
    exp_word_t    e;
    sInstAlignOut x;
    Address       a;
    held_v = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!(mon_en && rst_ni)) begin
        held_v = 1'b0;
      end else begin
        if (fetch_req_o) begin
          if (m_fetch.size() == 0) check("fetch_extra", fetch_req_o, 1'b0);
          else check("fetch_adr", fetch_adr_o, m_fetch.pop_front());
        end
        if (held_v && ins_v_o) check("hold_stable", ins_o, held);
        held_v = ins_v_o && !ins_rdy_i;
        held   = ins_o;
        if (ins_v_o && ins_o.ip == hold_ip) hold_seen++;
        if (flush_i) begin
          m_words.delete();
          m_line_next.delete();
          m_stream   = (m_stream + 1) % 64;
          m_pend     = 1'b1;
          m_pend_idx = int'(rdx_i.redirect_ip[5:2]);
          m_fetch.push_back({rdx_i.redirect_ip[31:6], 6'd0});
        end else begin
          if (ins_v_o && ins_rdy_i) begin
            n_hs++;
            if (m_words.size() == 0) begin
              check("ins_extra", ins_v_o, 1'b0);
            end else begin
              e = m_words.pop_front();
              x.Stream        = m_stream[5:0];
              x.ip            = e.ip;
              x.pip           = e.ip + 4;
              x.predict_taken = e.pt;
              x.ir            = e.ir;
              check("ins", ins_o, x);
              if (e.last) begin
                a = m_line_next.pop_front();
                if (!PF) m_fetch.push_back(a);
                else if (m_line_next.size() > 0) m_fetch.push_back(m_line_next[0]);
              end
            end
          end
          if (line_v_i && line_rdy_o) model_accept(line_i);
        end
      end
    end
  end

  initial begin : rdy_driver
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0: ins_rdy_i = 1'b1;
        1: ins_rdy_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (ins_v_o && ins_o.ip == hold_ip && hold_cnt < 5) begin
            ins_rdy_i = 1'b0;
            hold_cnt++;
          end else begin
            ins_rdy_i = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_line(input Address ip, input logic [5:0] s, input logic pt);
    int unsigned n;
    line_i.Stream        = s;
    line_i.ip            = ip;
    line_i.pip           = ip + 4;
    line_i.predict_taken = pt;
    for (int i = 0; i < 16; i++) line_i.cacheline[i*32 +: 32] = $urandom;
    line_v_i = 1'b1;
    n = 0;
    while (!line_rdy_o && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("line_accept_timeout", line_rdy_o, 1'b1);
    tick();
    line_v_i = 1'b0;
  endtask

  task automatic do_flush(input Address rip);
    rdx_i.redirect_ip = rip;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while (m_words.size() > 0 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check({tag, "_drain_timeout"}, m_words.size(), 0);
    repeat (3) tick();
    check({tag, "_fetch_pending"}, m_fetch.size(), 0);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned base_hs, cnt, gap, exp_s, prev_s;
    bit          saw_wrap;
    Address      a;
    line_i = '0;
    rdx_i  = '0;

    // reset state
    #23;
    check("rst_ins_v", ins_v_o, 1'b0);
    check("rst_ins_o", ins_o, '0);
    check("rst_line_rdy", line_rdy_o, 1'b0);
    check("rst_fetch_req", fetch_req_o, 1'b0);
    check("rst_fetch_adr", fetch_adr_o, RSTIP);
    check("rst_stream", stream_o, 6'd0);
    m_fetch.push_back(RSTIP);
    mon_en = 1'b1;
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    tick();
    check("boot_fetch_req", fetch_req_o, 1'b1);
    check("boot_line_rdy", line_rdy_o, 1'b1);

    // full line from reset vector
    base_hs = n_hs;
    send_line(RSTIP, 6'd0, 1'b1);
    wait_drain("t_full");
    check("t_full_count", n_hs - base_hs, 16);

    // partial line starting at word 14
    base_hs = n_hs;
    send_line(32'h0000_1038, 6'd0, 1'b0);
    wait_drain("t_tail");
    check("t_tail_count", n_hs - base_hs, 2);

    // stall on word 3 for 5 cycles
    hold_ip = 32'h0000_300C;
    hold_seen = 0;
    hold_cnt = 0;
    rdy_mode = 2;
    base_hs = n_hs;
    send_line(32'h0000_3000, 6'd0, 1'b1);
    wait_drain("t_hold");
    check("t_hold_count", n_hs - base_hs, 16);
    check("t_hold_cycles", hold_seen, 6);
    rdy_mode = 0;
    hold_ip = '1;

    // flush colliding with a line
    line_i.Stream = 6'd0;
    line_i.ip = 32'h0000_5000;
    line_i.predict_taken = 1'b0;
    for (int i = 0; i < 16; i++) line_i.cacheline[i*32 +: 32] = $urandom;
    line_v_i = 1'b1;
    rdx_i.redirect_ip = 32'h0000_2004;
    flush_i = 1'b1;
    tick();
    line_v_i = 1'b0;
    flush_i = 1'b0;
    check("t_flush_stream", stream_o, 6'd1);
    check("t_flush_ins_v", ins_v_o, 1'b0);
    base_hs = n_hs;
    send_line(32'h0000_2000, 6'd1, 1'b1);
    wait_drain("t_redirect");
    check("t_redirect_count", n_hs - base_hs, 15);

    // stale stream is dropped
    send_line(32'h0000_6000, 6'd0, 1'b1);
    cnt = 0;
    repeat (25) begin
      tick();
      if (ins_v_o) cnt++;
    end
    check("t_stale_ins_v", cnt, 0);

    // 64 flushes through the stream wrap
    exp_s = int'(stream_o);
    saw_wrap = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev_s = int'(stream_o);
      a = $urandom;
      do_flush(a);
      exp_s = (exp_s + 1) % 64;
      check("t_wrap_stream", stream_o, exp_s[5:0]);
      if (prev_s == 63 && stream_o == 6'd0) saw_wrap = 1'b1;
    end
    check("t_wrap_seen", saw_wrap, 1'b1);
    repeat (2) tick();

    // back-to-back lines across a line boundary
    do_flush(32'h0000_7000);
    base_hs = n_hs;
    gap = 0;
    fork
      begin
        send_line(32'h0000_7000, m_stream[5:0], 1'b0);
        send_line(32'h0000_7040, m_stream[5:0], 1'b0);
      end
      begin
        cnt = 0;
        while (!ins_v_o && cnt < 300) begin tick(); cnt++; end
        while (n_hs - base_hs < 32 && cnt < 600) begin
          tick();
          cnt++;
          if (!ins_v_o && n_hs - base_hs < 32) gap++;
        end
        if (cnt >= 600) check("t_b2b_timeout", n_hs - base_hs, 32);
      end
    join
    wait_drain("t_b2b");
    if (PF) check("t_b2b_gap", gap, 0);
    else    check("t_b2b_bubble", (gap >= 1), 1'b1);

    // reset in the middle of a line
    base_hs = n_hs;
    send_line(32'h0000_8000, m_stream[5:0], 1'b0);
    cnt = 0;
    while (n_hs - base_hs < 4 && cnt < 100) begin tick(); cnt++; end
    #2;
    rst_ni = 1'b0;
    mon_en = 1'b0;
    #1;
    model_reset();
    check("t_midrst_ins_v", ins_v_o, 1'b0);
    #20;
    m_fetch.push_back(RSTIP);
    mon_en = 1'b1;
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    cnt = 0;
    repeat (25) begin
      tick();
      if (ins_v_o) cnt++;
    end
    check("t_midrst_no_ins", cnt, 0);
    check("t_midrst_stream", stream_o, 6'd0);
    check("t_midrst_fetch", m_fetch.size(), 0);

    // randomized traffic
    rdy_mode = 1;
    a = 32'h0010_0000;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: do_flush($urandom);
        1: send_line($urandom, m_stream[5:0] ^ 6'h20, 1'($urandom));
        2: begin
          a = {$urandom_range(0, 32'h03FF_FFFF), 4'($urandom), 2'b00};
          send_line(a, m_stream[5:0], 1'($urandom));
        end
        default: begin
          a = {a[31:6] + 26'd1, 6'd0};
          send_line(a, m_stream[5:0], 1'($urandom));
        end
      endcase
    end
    rdy_mode = 0;
    wait_drain("t_rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
